mdu_hilo_sequencer: RTL and testbench
=====================================

# mdu_hilo_sequencer

Iterative multiply/divide unit with its own HI/LO register pair. It serves the MIPS-style core's mult, multu, div and divu ALU control codes. The core issues one operation at a time with a start pulse, then stalls on `busy` while the block runs a 32-step shift-add or restoring-division sequence. HI/LO are written once, at completion. The block also accepts direct HI/LO writes (mthi/mtlo) and exposes HI/LO for mfhi/mflo.

## Interface
- `XLEN`, 32: operand and HI/LO width. The latency figures below assume 32.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: operation request, sampled only in IDLE.
- `aluCtrl` in 5: operation code. 01001 mult, 01110 multu, 01010 div, 01101 divu. Any other value with `start` is ignored.
- `srcA` in XLEN: multiplicand or dividend, sampled with `start`.
- `srcB` in XLEN: multiplier or divisor, sampled with `start`.
- `mthi` in 1: write `wdata` into HI.
- `mtlo` in 1: write `wdata` into LO.
- `wdata` in XLEN: data for direct HI/LO writes.
- `busy` out 1: operation in progress; the core uses it as a stall.
- `done` out 1: one-cycle pulse in the cycle after HI/LO are updated.
- `hi` out XLEN: HI register, registered.
- `lo` out XLEN: LO register, registered.

## Operation
- States:
  - IDLE: accepts `start`.
  - PREP: takes magnitudes of signed operands and records the result signs.
  - RUN: 32 iterations, 5-bit step counter 0..31.
  - FIX: applies sign correction, writes HI/LO, pulses `done`.
- Transitions:
  - IDLE→PREP on `start` with a valid code. Operands and opcode are latched.
  - PREP→RUN always; counter cleared.
  - RUN→FIX when the counter is 31.
  - FIX→IDLE always.
- Divide by zero (`srcB`=0 for div/divu): PREP goes straight to FIX. FIX writes LO=FFFFFFFF and HI=raw `srcA`, with no sign fix.
- Multiply:
  - 64-bit product built by shift-add on magnitudes.
  - Signed (mult): product negated if the operand signs differ.
  - HI=product[63:32], LO=product[31:0].
- Divide:
  - Restoring division on magnitudes.
  - Signed (div): quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - LO=quotient, HI=remainder.
  - div 80000000/FFFFFFFF gives LO=80000000, HI=0.
- `mthi`/`mtlo` while busy: ignored, HI/LO unchanged.
- `mthi`/`mtlo` in IDLE: applied at the edge. If `start` is accepted at the same edge, the write still lands, and the operation result overwrites it at FIX.
- `start` while not IDLE is ignored; no queueing.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
- `start` accepted at edge N:
  - `busy`=1 from after edge N until edge N+34.
  - FIX is entered at edge N+33.
  - HI/LO are updated and `done`=1 at edge N+34, for one cycle; `busy` returns to 0 at that same edge.
  - Divide by zero: HI/LO updated at edge N+2, `done` for one cycle.
- A new `start` is accepted in the same cycle that `done` is high (state is IDLE).
- `hi`/`lo` hold their old values throughout RUN; intermediate values are never visible.
- Reset asserted mid-operation: immediately IDLE, HI/LO=0, `busy`/`done`=0. No partial write.

## Test plan
- multu FFFFFFFF×FFFFFFFF → HI=FFFFFFFE, LO=00000001. `done` at edge N+34; `busy` high for exactly 34 cycles.
- mult FFFFFFFD(−3)×00000007 → HI=FFFFFFFF, LO=FFFFFFEB. divu 00000064/00000007 → LO=0000000E, HI=00000002.
- div FFFFFFF9(−7)/00000002 → LO=FFFFFFFD, HI=FFFFFFFF. div 80000000/FFFFFFFF → LO=80000000, HI=0.
- divu 12345678/0 → LO=FFFFFFFF, HI=12345678, `done` at edge N+2.
- `start` and `mthi` pulsed mid-RUN → both ignored, original result unchanged. `start` with code 00000 in IDLE → `busy` stays 0.
- `rst_n` low at cycle 10 of a mult → `hi`/`lo`/`busy`/`done` all 0 asynchronously. Next multu 2×3 after release → LO=6, HI=0.

Source files
------------

// File: rtl/mdu_hilo_sequencer.sv
// rtl/mdu_hilo_sequencer.sv - iterative mult/multu/div/divu unit with HI/LO register pair
module mdu_hilo_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      aluCtrl,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int              CW   = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);

  localparam logic [4:0] OP_MULT  = 5'b01001;
  localparam logic [4:0] OP_MULTU = 5'b01110;
  localparam logic [4:0] OP_DIV   = 5'b01010;
  localparam logic [4:0] OP_DIVU  = 5'b01101;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [XLEN-1:0]     a_q;        // raw srcA, kept for the divide-by-zero HI value
  logic [XLEN-1:0]     b_q;        // raw srcB
  logic [XLEN-1:0]     m_q;        // multiplicand magnitude or divisor magnitude
  logic [2*XLEN-1:0]   acc_q;      // {upper, lower}: product/multiplier or remainder/quotient
  logic                is_mul_q;
  logic                is_sgn_q;
  logic                neg_q;      // negate product / quotient
  logic                rem_neg_q;  // negate remainder (dividend sign)
  logic                div0_q;
  logic [XLEN-1:0]     hi_q;
  logic [XLEN-1:0]     lo_q;
  logic                busy_q;
  logic                done_q;

  logic                op_valid;
  logic                op_mul;
  logic                op_sgn;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_step_d;
  logic [XLEN:0]       rem_sh;
  logic [XLEN-1:0]     rem_diff;
  logic [2*XLEN-1:0]   div_step_d;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix;
  logic [XLEN-1:0]     rem_fix;

  // Decode the requested operation into multiply/divide and signed/unsigned.
  always_comb begin
    op_valid = 1'b0;
    op_mul   = 1'b0;
    op_sgn   = 1'b0;
    case (aluCtrl)
      OP_MULT:  begin op_valid = 1'b1; op_mul = 1'b1; op_sgn = 1'b1; end
      OP_MULTU: begin op_valid = 1'b1; op_mul = 1'b1; op_sgn = 1'b0; end
      OP_DIV:   begin op_valid = 1'b1; op_mul = 1'b0; op_sgn = 1'b1; end
      OP_DIVU:  begin op_valid = 1'b1; op_mul = 1'b0; op_sgn = 1'b0; end
      default:  begin op_valid = 1'b0; op_mul = 1'b0; op_sgn = 1'b0; end
    endcase
  end

  // Operand magnitudes, one shift-add step, one restoring-divide step and the final sign fix.
  always_comb begin
    a_mag      = (is_sgn_q && a_q[XLEN-1]) ? -a_q : a_q;
    b_mag      = (is_sgn_q && b_q[XLEN-1]) ? -b_q : b_q;

    mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
    mul_step_d = {mul_sum, acc_q[XLEN-1:1]};

    rem_sh     = acc_q[2*XLEN-1:XLEN-1];
    rem_diff   = rem_sh[XLEN-1:0] - m_q;
    if (rem_sh >= {1'b0, m_q}) begin
      div_step_d = {rem_diff, acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_step_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    prod_fix   = neg_q ? -acc_q : acc_q;
    quo_fix    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix    = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  // Sequencer: IDLE -> PREP -> RUN x XLEN -> FIX, with HI/LO written only in IDLE or FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      is_mul_q  <= 1'b0;
      is_sgn_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mthi) hi_q <= wdata;
          if (mtlo) lo_q <= wdata;
          if (start && op_valid) begin
            a_q      <= srcA;
            b_q      <= srcB;
            is_mul_q <= op_mul;
            is_sgn_q <= op_sgn;
            busy_q   <= 1'b1;
            state_q  <= S_PREP;
          end
        end
        S_PREP: begin
          neg_q     <= is_sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          rem_neg_q <= is_sgn_q & a_q[XLEN-1];
          div0_q    <= !is_mul_q && (b_q == '0);
          cnt_q     <= '0;
          if (is_mul_q) begin
            m_q   <= a_mag;
            acc_q <= {{XLEN{1'b0}}, b_mag};
          end else begin
            m_q   <= b_mag;
            acc_q <= {{XLEN{1'b0}}, a_mag};
          end
          state_q <= (!is_mul_q && (b_q == '0)) ? S_FIX : S_RUN;
        end
        S_RUN: begin
          acc_q <= is_mul_q ? mul_step_d : div_step_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          if (div0_q) begin
            lo_q <= '1;
            hi_q <= a_q;
          end else if (is_mul_q) begin
            hi_q <= prod_fix[2*XLEN-1:XLEN];
            lo_q <= prod_fix[XLEN-1:0];
          end else begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo_sequencer.sv
// tb/tb_mdu_hilo_sequencer.sv - scoreboard bench for mdu_hilo_sequencer
module tb_mdu_hilo_sequencer;

  localparam logic [4:0] OP_MULT  = 5'b01001;
  localparam logic [4:0] OP_MULTU = 5'b01110;
  localparam logic [4:0] OP_DIV   = 5'b01010;
  localparam logic [4:0] OP_DIVU  = 5'b01101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  aluCtrl;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_hilo_sequencer #(.XLEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .aluCtrl (aluCtrl),
    .srcA    (srcA),
    .srcB    (srcB),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc_edge;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_cnt = 0;
  int   busy_cnt = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk_eq("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk_eq("hi", {32'd0, hi}, {32'd0, mon_e.hi});
          chk_eq("lo", {32'd0, lo}, {32'd0, mon_e.lo});
          chk_eq("done_latency", 64'(edge_cnt - mon_e.acc_edge), 64'(mon_e.lat));
          chk_eq("busy_cycles", 64'(busy_cnt), 64'(mon_e.lat));
        end
        busy_cnt = 0;
      end
    end
  end

  // Called just after a falling edge; the start is taken at the next rising edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int lat);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.lat = lat; e.acc_edge = edge_cnt + 1;
    sb.push_back(e);
    aluCtrl = op; srcA = a; srcB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk_eq("drain", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ehi, output logic [31:0] elo, output int lat);
    logic [63:0] p;
    longint      sa, sbv, q, r;
    lat = 34;
    ehi = 32'd0; elo = 32'd0;
    case (op)
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        ehi = p[63:32]; elo = p[31:0];
      end
      OP_MULT: begin
        sa = longint'($signed(a)); sbv = longint'($signed(b));
        p = 64'(sa * sbv);
        ehi = p[63:32]; elo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          ehi = a; elo = 32'hFFFF_FFFF; lat = 2;
        end else if (op == OP_DIVU) begin
          elo = a / b; ehi = a % b;
        end else begin
          sa = longint'($signed(a)); sbv = longint'($signed(b));
          q = sa / sbv; r = sa % sbv;
          elo = 32'(q); ehi = 32'(r);
        end
      end
    endcase
  endtask

  logic [4:0]  ops [4];
  logic [4:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  int          r_lat;

  initial begin
    ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
    rst_n = 1'b0; start = 1'b0; aluCtrl = 5'd0; srcA = '0; srcB = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk_eq("reset_hi",   {32'd0, hi}, 64'd0);
    chk_eq("reset_lo",   {32'd0, lo}, 64'd0);
    chk_eq("reset_busy", {63'd0, busy}, 64'd0);
    chk_eq("reset_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34); drain();
    issue(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34); drain();
    issue(OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 34); drain();
    issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34); drain();
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34); drain();
    issue(OP_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 2);  drain();
    issue(OP_DIV,   32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 2);  drain();

    // direct HI/LO writes in IDLE
    mthi = 1'b1; wdata = 32'h1111_2222; @(negedge clk); mthi = 1'b0;
    mtlo = 1'b1; wdata = 32'h3333_4444; @(negedge clk); mtlo = 1'b0;
    chk_eq("mthi_idle", {32'd0, hi}, 64'h1111_2222);
    chk_eq("mtlo_idle", {32'd0, lo}, 64'h3333_4444);

    // a new start accepted in the cycle done is high
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 34);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    chk_eq("b2b_done_seen", {63'd0, done}, 64'd1);
    issue(OP_DIVU, 32'd1000, 32'd10, 32'd0, 32'd100, 34);
    drain();

    // mthi landing at the same edge as an accepted start, then overwritten at FIX
    sb.push_back('{hi: 32'd0, lo: 32'd35, lat: 34, acc_edge: edge_cnt + 1});
    aluCtrl = OP_MULTU; srcA = 32'd5; srcB = 32'd7; start = 1'b1;
    mthi = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk_eq("mthi_with_start", {32'd0, hi}, 64'hCAFE_F00D);
    repeat (10) @(negedge clk);
    chk_eq("hi_hold_run", {32'd0, hi}, 64'hCAFE_F00D);
    chk_eq("lo_hold_run", {32'd0, lo}, 64'd100);
    // start and mthi/mtlo mid-RUN are ignored
    aluCtrl = OP_DIVU; srcA = 32'd9; srcB = 32'd3; start = 1'b1;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk_eq("mthi_busy", {32'd0, hi}, 64'hCAFE_F00D);
    chk_eq("mtlo_busy", {32'd0, lo}, 64'd100);
    drain();
    repeat (3) @(negedge clk);
    chk_eq("no_queued_start", {63'd0, busy}, 64'd0);

    // invalid code is ignored
    aluCtrl = 5'b00000; srcA = 32'd3; srcB = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_eq("bad_code_busy0", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk_eq("bad_code_busy1", {63'd0, busy}, 64'd0);

    // model-checked random operations
    for (int i = 0; i < 10; i++) begin
      r_op = ops[$urandom_range(0, 3)];
      r_a  = $urandom;
      r_b  = $urandom >> $urandom_range(0, 31);
      model(r_op, r_a, r_b, r_hi, r_lo, r_lat);
      issue(r_op, r_a, r_b, r_hi, r_lo, r_lat);
      drain();
    end

    // asynchronous reset in the middle of a multiply
    issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34); drain();
    issue(OP_MULT, 32'h0000_1234, 32'h0000_5678, 32'h0, 32'h0, 34);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("async_rst_hi",   {32'd0, hi}, 64'd0);
    chk_eq("async_rst_lo",   {32'd0, lo}, 64'd0);
    chk_eq("async_rst_busy", {63'd0, busy}, 64'd0);
    chk_eq("async_rst_done", {63'd0, done}, 64'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk_eq("post_rst_idle", {63'd0, busy}, 64'd0);
    issue(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 34); drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
